// File: rtl/eth_lcd_pkg.sv
// Shared types and helpers for the Ethernet-to-LCD hex character path.
package eth_lcd_pkg;

  typedef enum logic [2:0] {
    S_CLEAR = 3'd0,
    S_WAIT  = 3'd1,
    S_HI    = 3'd2,
    S_LO    = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  localparam int CHAR_CNT         = 32;
  localparam int BYTES_PER_SCREEN = 16;

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
    logic [7:0] r;
    if (n < 4'd10) begin
      r = 8'h30 + {4'h0, n};
    end else begin
      r = 8'h41 + {4'h0, n} - 8'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/eth_charram.sv
// 32x8 character RAM: synchronous write port, asynchronous read port, no reset.
module eth_charram
  import eth_lcd_pkg::*;
(
  input  logic       clk,
  input  logic       i_we,
  input  logic [4:0] i_waddr,
  input  logic [7:0] i_wdata,
  input  logic [4:0] i_raddr,
  output logic [7:0] o_rdata
);

  logic [7:0] r_mem [CHAR_CNT];

  // Write port; a same-cycle read of the written cell still sees the old value.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/eth_hex_charbuf.sv
// Renders the first 16 bytes of each received frame as 32 hex characters for
// the LCD, holds the screen for HOLD_CYCLES, then blanks it for the next frame.
module eth_hex_charbuf
  import eth_lcd_pkg::*;
#(
  parameter int         HOLD_CYCLES = 50000000,
  parameter logic [7:0] BLANK_CHAR  = 8'h20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  input  logic [4:0] charmem_addr,
  output logic [7:0] charmem_bus,
  output logic       frame_done,
  output logic       overflow
);

  localparam int         HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [5:0] WPTR_FULL = 6'(2 * BYTES_PER_SCREEN);
  localparam logic [4:0] CLR_LAST  = 5'(CHAR_CNT - 1);

  state_t          r_state;
  logic [4:0]      r_clr_cnt;
  logic [5:0]      r_wptr;
  logic [HW-1:0]   r_hold_cnt;
  logic [7:0]      r_byte_q;
  logic            r_last_q;
  logic            r_in_ready;
  logic            r_frame_done;
  logic            r_overflow;

  logic            w_xfer;
  logic            w_room;
  logic            w_we;
  logic [4:0]      w_waddr;
  logic [7:0]      w_wdata;

  assign w_xfer = in_valid & r_in_ready;
  assign w_room = (r_wptr < WPTR_FULL);

  // RAM write decode: clear sweep, then high and low nibble of the held byte.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = 5'd0;
    w_wdata = BLANK_CHAR;
    case (r_state)
      S_CLEAR: begin
        w_we    = 1'b1;
        w_waddr = r_clr_cnt;
        w_wdata = BLANK_CHAR;
      end
      S_HI: begin
        if (w_room) begin
          w_we    = 1'b1;
          w_waddr = r_wptr[4:0];
          w_wdata = nibble_to_ascii(r_byte_q[7:4]);
        end else begin
          w_we    = 1'b0;
        end
      end
      S_LO: begin
        if (w_room) begin
          w_we    = 1'b1;
          w_waddr = r_wptr[4:0] + 5'd1;
          w_wdata = nibble_to_ascii(r_byte_q[3:0]);
        end else begin
          w_we    = 1'b0;
        end
      end
      default: begin
        w_we    = 1'b0;
      end
    endcase
  end

  // Frame sequencer; in_ready is registered and only high in S_WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_CLEAR;
      r_clr_cnt    <= 5'd0;
      r_wptr       <= 6'd0;
      r_hold_cnt   <= '0;
      r_byte_q     <= 8'h00;
      r_last_q     <= 1'b0;
      r_in_ready   <= 1'b0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_CLEAR: begin
          r_clr_cnt  <= r_clr_cnt + 5'd1;
          r_in_ready <= 1'b0;
          if (r_clr_cnt == CLR_LAST) begin
            r_state    <= S_WAIT;
            r_wptr     <= 6'd0;
            r_overflow <= 1'b0;
            r_in_ready <= 1'b1;
          end
        end
        S_WAIT: begin
          if (w_xfer) begin
            r_byte_q   <= in_data;
            r_last_q   <= in_last;
            r_in_ready <= 1'b0;
            r_state    <= S_HI;
          end
        end
        S_HI: begin
          r_state <= S_LO;
        end
        S_LO: begin
          // Extra bytes are swallowed so the sender never stalls on overflow.
          if (w_room) begin
            r_wptr <= r_wptr + 6'd2;
          end else begin
            r_overflow <= 1'b1;
          end
          if (r_last_q) begin
            r_frame_done <= 1'b1;
            r_hold_cnt   <= '0;
            r_state      <= S_HOLD;
          end else begin
            r_in_ready   <= 1'b1;
            r_state      <= S_WAIT;
          end
        end
        S_HOLD: begin
          r_hold_cnt <= r_hold_cnt + HW'(1);
          if (r_hold_cnt == HOLD_LAST) begin
            r_state    <= S_CLEAR;
            r_clr_cnt  <= 5'd0;
            r_overflow <= 1'b0;
          end
        end
        default: begin
          r_state    <= S_CLEAR;
          r_clr_cnt  <= 5'd0;
          r_in_ready <= 1'b0;
        end
      endcase
    end
  end

  eth_charram u_charram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (charmem_addr),
    .o_rdata (charmem_bus)
  );

  assign in_ready   = r_in_ready;
  assign frame_done = r_frame_done;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_eth_hex_charbuf.sv
// Randomised scoreboard bench: the driver queues each frame's expected screen,
// a monitor checks screen, overflow and timing whenever the DUT signals.
module tb_eth_hex_charbuf;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic [4:0] charmem_addr;
  logic [7:0] charmem_bus;
  logic       frame_done;
  logic       overflow;

  int n_checks = 0;
  int n_errors = 0;

  logic [255:0] exp_scr_q[$];
  bit           exp_ovf_q[$];

  localparam logic [255:0] BLANK_SCR = {32{8'h20}};

  eth_hex_charbuf #(.HOLD_CYCLES(4), .BLANK_CHAR(8'h20)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .charmem_addr (charmem_addr),
    .charmem_bus  (charmem_bus),
    .frame_done   (frame_done),
    .overflow     (overflow)
  );

  always #50 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference screen: two uppercase hex digits per byte for the first 16 bytes.
  function automatic logic [255:0] screen_of(input logic [7:0] b[$]);
    string hx;
    logic [255:0] s;
    hx = "0123456789ABCDEF";
    s = BLANK_SCR;
    for (int i = 0; i < b.size() && i < 16; i++) begin
      s[(2*i)*8 +: 8]   = hx[b[i][7:4]];
      s[(2*i+1)*8 +: 8] = hx[b[i][3:0]];
    end
    return s;
  endfunction

  task automatic sweep(input logic [255:0] exp, input string nm);
    int bad = 0;
    int first = -1;
    logic [7:0] got_first = 8'h00;
    for (int a = 0; a < 32; a++) begin
      charmem_addr = 5'(a);
      #1;
      if (charmem_bus !== exp[a*8 +: 8]) begin
        if (first < 0) begin
          first = a;
          got_first = charmem_bus;
        end
        bad++;
      end
    end
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("FAIL %s addr %0d got %02h want %02h (%0d cells wrong)",
               nm, first, got_first, exp[first*8 +: 8], bad);
    end
  endtask

  // Monitor: reacts to frame_done and to in_ready rising, checks against queue.
  initial begin : monitor
    int lowcnt = 0;
    int cyc = 0;
    int fd_cyc = -1000;
    int nbytes = 0;
    int last_xfer = -1000;
    bit after_reset = 1'b1;
    bit prev_ready = 1'b0;
    logic [255:0] e_scr;
    bit e_ovf;
    charmem_addr = 5'd0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        lowcnt = 0; nbytes = 0; after_reset = 1'b1; prev_ready = 1'b0;
        continue;
      end
      if (frame_done) begin
        chk("frame_done_latency", cyc - last_xfer, 3);
        if (exp_scr_q.size() == 0) begin
          chk("frame_done_unexpected", 1, 0);
        end else begin
          e_scr = exp_scr_q.pop_front();
          e_ovf = exp_ovf_q.pop_front();
          chk("overflow_at_done", int'(overflow), int'(e_ovf));
          sweep(e_scr, "frame_screen");
        end
        fd_cyc = cyc;
        nbytes = 0;
      end
      if (in_ready) begin
        if (!prev_ready) begin
          if (lowcnt > 2) begin
            if (after_reset) chk("reset_clear_len", lowcnt, 32);
            else             chk("hold_clear_len", cyc - fd_cyc, 36);
            chk("overflow_after_clear", int'(overflow), 0);
            sweep(BLANK_SCR, "blank_screen");
            after_reset = 1'b0;
          end else begin
            chk("byte_gap", lowcnt, 2);
            chk("overflow_mid_frame", int'(overflow), int'(nbytes > 16));
          end
        end
        if (in_valid) begin
          nbytes++;
          last_xfer = cyc;
        end
        lowcnt = 0;
      end else begin
        lowcnt++;
      end
      prev_ready = in_ready;
    end
  end

  task automatic send_byte(input logic [7:0] d, input bit last, input int idle,
                           output int waited);
    repeat (idle) @(posedge clk);
    #5;
    in_valid = 1'b1; in_data = d; in_last = last;
    waited = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 500) begin
        chk("ready_timeout", waited, 0);
        break;
      end
    end
    @(posedge clk);
    #5;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b[$], input bit has_last, input int max_idle);
    int w;
    if (has_last) begin
      exp_scr_q.push_back(screen_of(b));
      exp_ovf_q.push_back(b.size() > 16);
    end
    for (int i = 0; i < b.size(); i++) begin
      send_byte(b[i], has_last && (i == b.size() - 1), int'($urandom_range(max_idle, 0)), w);
    end
  endtask

  task automatic rand_frame(output logic [7:0] b[$], input int len);
    b = {};
    for (int i = 0; i < len; i++) b.push_back(8'($urandom));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin : driver
    logic [7:0] fb[$];
    int w;
    int t;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    #1;
    chk("reset_in_ready", int'(in_ready), 0);
    chk("reset_frame_done", int'(frame_done), 0);
    chk("reset_overflow", int'(overflow), 0);
    do_reset();

    fb = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_frame(fb, 1'b1, 3);

    fb = {};
    for (int i = 0; i < 20; i++) fb.push_back(8'(i));
    send_frame(fb, 1'b1, 0);

    rand_frame(fb, int'($urandom_range(20, 1)));
    send_frame(fb, 1'b1, 2);
    fb = '{8'h9A};
    exp_scr_q.push_back(screen_of(fb));
    exp_ovf_q.push_back(1'b0);
    send_byte(8'h9A, 1'b1, 0, w);
    chk("hold_backpressure_wait", w, 38);

    for (int k = 0; k < 6; k++) begin
      rand_frame(fb, int'($urandom_range(24, 1)));
      send_frame(fb, 1'b1, 3);
    end

    // Abort in S_LO of byte 3.
    fb = '{8'h11, 8'h22, 8'h33};
    send_frame(fb, 1'b0, 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_lo_in_ready", int'(in_ready), 0);
    chk("abort_lo_frame_done", int'(frame_done), 0);
    chk("abort_lo_overflow", int'(overflow), 0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    rand_frame(fb, int'($urandom_range(10, 1)));
    send_frame(fb, 1'b1, 2);

    // Abort while waiting with overflow already flagged.
    rand_frame(fb, 17);
    send_frame(fb, 1'b0, 0);
    repeat (3) @(posedge clk);
    #3;
    chk("pre_abort_in_ready", int'(in_ready), 1);
    chk("pre_abort_overflow", int'(overflow), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_wait_in_ready", int'(in_ready), 0);
    chk("abort_wait_overflow", int'(overflow), 0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    rand_frame(fb, int'($urandom_range(24, 1)));
    send_frame(fb, 1'b1, 3);

    t = 0;
    while (exp_scr_q.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("scoreboard_drained", exp_scr_q.size(), 0);
    repeat (45) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/eth_hex_charbuf.md
Name: eth_hex_charbuf

Overview:
- Upstream neighbour of the LCD character path; replaces the fixed character ROM on the eth-test board.
- Accepts a received Ethernet byte stream over a valid/ready handshake and renders the first 16 bytes of each frame as 32 uppercase ASCII hex characters in a 32x8 character RAM.
- The LCD driver reads that RAM through the same 5-bit address / 8-bit data pair it uses today.
- Each frame is held on screen for a programmable time; the buffer is then blanked and the next frame is accepted.

Parameters:
- HOLD_CYCLES, 50000000, clk cycles the completed frame stays displayed before the next clear (1 s at 50 MHz); minimum 1.
- BLANK_CHAR, 8'h20, character written by the clear sweep.

Ports:
- clk  in  1  system clock; every register is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_data/in_last are valid this cycle.
- in_data  in  8  received frame byte.
- in_last  in  1  marks the final byte of the frame.
- in_ready  out  1  block can accept a byte this cycle.
- charmem_addr  in  5  LCD character read address, 0..31.
- charmem_bus  out  8  character at charmem_addr.
- frame_done  out  1  one-cycle pulse when the last byte's characters have been written.
- overflow  out  1  frame exceeded 16 bytes; cleared at the start of each clear sweep.

Behaviour:
- Read port is combinational: charmem_bus = mem[charmem_addr]. It has no reset and is not blocked during writes. Same-cycle write and read of one address returns the old value.
- Handshake: a byte transfers on a clk edge where in_valid & in_ready are both 1. in_data and in_last are captured into byte_q and last_q at that edge.
- Reset values: state=S_CLEAR, clr_cnt=0, wptr=0, hold_cnt=0, in_ready=0, frame_done=0, overflow=0. RAM contents are undefined until the first sweep completes.
- S_CLEAR:
  - Each cycle writes BLANK_CHAR to mem[clr_cnt], then clr_cnt+1.
  - After writing address 31: go to S_WAIT, wptr=0, overflow=0.
  - Duration is exactly 32 cycles; in_ready=0.
- S_WAIT:
  - in_ready=1.
  - On a transfer, go to S_HI. Otherwise stay.
- S_HI:
  - in_ready=0.
  - If wptr<32: write hex(byte_q[7:4]) to mem[wptr].
  - Go to S_LO.
- S_LO:
  - in_ready=0.
  - If wptr<32: write hex(byte_q[3:0]) to mem[wptr+1] and set wptr=wptr+2. wptr is 6 bits and saturates at 32.
  - If wptr==32 on entry: no write, set overflow=1.
  - If last_q: pulse frame_done, hold_cnt=0, go to S_HOLD. Otherwise go to S_WAIT.
- hex(n): n<10 gives 8'h30+n; otherwise 8'h41+(n-10), i.e. 'A'..'F'.
- Throughput: one byte per 3 cycles; in_ready has a 2-cycle gap after every transfer.
- Overflow:
  - Bytes 17 and later are still accepted (in_ready=1) and discarded. The sender is never stalled by the overflow.
  - overflow stays 1 through S_HOLD.
- S_HOLD:
  - in_ready=0; hold_cnt increments each cycle.
  - When hold_cnt==HOLD_CYCLES-1: go to S_CLEAR, clr_cnt=0.
  - Bytes offered during S_HOLD and S_CLEAR are back-pressured, not dropped.
- A frame shorter than 16 bytes leaves the remaining cells at BLANK_CHAR.
- A zero-length frame cannot occur: in_last always travels with a byte.
- rst_n asserted mid-operation (any state): registers return to reset values immediately. A partial frame is abandoned; the sender must restart its frame after reset.
- in_valid with in_ready=0 is legal. The upstream block holds its data; no combinational path exists from in_valid to in_ready.

Decomposition:
- Shared package eth_lcd_pkg:
  - state enum {S_CLEAR, S_WAIT, S_HI, S_LO, S_HOLD};
  - constants CHAR_CNT=32, BYTES_PER_SCREEN=16;
  - function nibble_to_ascii.
- One sub-module: eth_charram, a 32x8 RAM with one synchronous write port and one asynchronous read port. The FSM, counters and hex conversion stay in eth_hex_charbuf.

Test Plan:
- Reset then idle, HOLD_CYCLES=4 → in_ready=0 for exactly 32 cycles after rst_n deassertion, then 1; all 32 addresses read 8'h20.
- Frame {8'hDE,8'hAD,8'hBE,8'hEF}, last on 4th byte:
  - addr0..7 read "DEADBEEF" (8'h44,45,41,44,42,45,45,46); addr8..31 read 8'h20;
  - frame_done pulses once, 1 cycle after the 4th byte's S_LO write;
  - overflow=0.
- 20-byte frame 8'h00..8'h13:
  - addr30,31 read "0F"; all 20 bytes are accepted with no stall; overflow=1 after byte 17;
  - frame_done pulses after byte 20; overflow returns to 0 at the next clear.
- Byte 8'h9A offered with in_valid held high during S_HOLD/S_CLEAR → no transfer until S_WAIT; it then appears at addr0,1 as 8'h39,8'h41.
- rst_n pulsed low while in S_LO of byte 3 → outputs return to reset values asynchronously; a full 32-cycle clear follows; the next frame starts at addr0.
- Back-to-back frames with HOLD_CYCLES=4 → the second frame's in_ready rises exactly 4+32 cycles after the first frame_done. The display shows only the second frame, and cells it does not write are blank.
